// File: rtl/mioc_pkg.sv
// Shared definitions for the MIOC flop-bank sequencer: op codes, FSM states,
// pin idle levels and a small sizing helper.
package mioc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_SET   = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    SAMPLE,
    RESP
  } state_e;

  localparam logic CLK_IDLE = 1'b1;
  localparam logic RST_IDLE = 1'b0;
  localparam logic SET_IDLE = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mioc_seq_timer.sv
// Loadable down-counter that times each sequencer phase; done is high once
// the loaded number of cycles has elapsed.
module mioc_seq_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Loading N-1 makes done rise after exactly N cycles in the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - CNT_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mioc_flop_seq.sv
// Sequencer that drives the MIOC open-drain flop bank pins and reads back q.
// Optional build macro MIOC_SEQ_VERIFY_EN adds a post-write readback check.
module mioc_flop_seq
  import mioc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] fl_rst,
  output logic [WIDTH-1:0] fl_clk,
  output logic [WIDTH-1:0] fl_d,
  output logic [WIDTH-1:0] fl_set,
  input  logic [WIDTH-1:0] fl_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int MAXC  = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CNT_W = $clog2(MAXC + 1);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] mask_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

`ifdef MIOC_SEQ_VERIFY_EN
  logic [WIDTH-1:0] data_q;

  function automatic logic [WIDTH-1:0] exp_val(input op_e op, input logic [WIDTH-1:0] d);
    case (op)
      OP_LOAD:  return d;
      OP_CLEAR: return '0;
      default:  return '1;
    endcase
  endfunction
`endif

  mioc_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer is reloaded on the same edge that changes phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(SETUP_CYC);
    case (state)
      IDLE:  tmr_load = cmd_valid && cmd_ready;
      SETUP: if (tmr_done && op_q != OP_READ) begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(PULSE_CYC);
      end
      PULSE: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(HOLD_CYC);
      end
      default: ;
    endcase
  end

  // Command fields are data only; they are qualified by the FSM state.
  always_ff @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      op_q   <= op_e'(cmd_op);
      mask_q <= cmd_mask;
`ifdef MIOC_SEQ_VERIFY_EN
      data_q <= cmd_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      fl_clk    <= {WIDTH{CLK_IDLE}};
      fl_rst    <= {WIDTH{RST_IDLE}};
      fl_set    <= {WIDTH{SET_IDLE}};
      fl_d      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef MIOC_SEQ_VERIFY_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          state     <= SETUP;
          cmd_ready <= 1'b0;
          if (op_e'(cmd_op) == OP_LOAD) fl_d <= cmd_data;
        end
        SETUP: if (tmr_done) begin
          if (op_q == OP_READ) begin
            state <= SAMPLE;
          end else begin
            state <= PULSE;
            // Only masked bits leave their idle level.
            case (op_q)
              OP_LOAD:  fl_clk <= {WIDTH{CLK_IDLE}} ^ mask_q;
              OP_CLEAR: fl_rst <= mask_q;
              OP_SET:   fl_set <= mask_q;
              default:  ;
            endcase
          end
        end
        PULSE: if (tmr_done) begin
          state  <= HOLD;
          fl_clk <= {WIDTH{CLK_IDLE}};
          fl_rst <= {WIDTH{RST_IDLE}};
          fl_set <= {WIDTH{SET_IDLE}};
        end
        HOLD: if (tmr_done) begin
`ifdef MIOC_SEQ_VERIFY_EN
          state <= SAMPLE;
`else
          state <= RESP;
`endif
        end
        SAMPLE: begin
          state    <= RESP;
          rsp_data <= fl_q;
`ifdef MIOC_SEQ_VERIFY_EN
          rsp_err  <= (op_q != OP_READ) && (|((fl_q ^ exp_val(op_q, data_q)) & mask_q));
`endif
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef MIOC_SEQ_VERIFY_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MIOC_SEQ_VERIFY_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mioc_flop_seq.sv
// Directed bench for mioc_flop_seq driving a behavioural MIOC flop bank.
module tb_mioc_flop_seq;

`ifdef MIOC_SEQ_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_mask = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] fl_rst, fl_clk, fl_d, fl_set;
  wire  [7:0] fl_q;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       stuck3 = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0] clk_tr[16], rst_tr[16], set_tr[16], d_tr[16], rd_tr[16];
  logic       rv_tr[16], er_tr[16];
  int         lat;

  always #5 clk = ~clk;

  mioc_flop_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_data  (cmd_data),
    .fl_rst    (fl_rst),
    .fl_clk    (fl_clk),
    .fl_d      (fl_d),
    .fl_set    (fl_set),
    .fl_q      (fl_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  // Behavioural flop bank: negedge clock, async reset has priority over set.
  for (genvar i = 0; i < 8; i++) begin : g_ff
    logic q;
    always @(negedge fl_clk[i] or posedge fl_rst[i] or posedge fl_set[i]) begin
      if (fl_rst[i])      q <= 1'b0;
      else if (fl_set[i]) q <= 1'b1;
      else                q <= fl_d[i];
    end
    assign fl_q[i] = (i == 3 && stuck3) ? 1'b0 : q;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL %s_ready_timeout: cmd_ready=%b want 1", name, cmd_ready);
    end
  endtask

  // Issues one command with rsp_ready low and records 16 cycles of pins.
  task automatic issue(input logic [1:0] op, input logic [7:0] m, input logic [7:0] d);
    cmd_op = op; cmd_mask = m; cmd_data = d; cmd_valid = 1'b1;
    wait_ready("issue");
    step();
    cmd_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 16; k++) begin
      clk_tr[k] = fl_clk; rst_tr[k] = fl_rst; set_tr[k] = fl_set; d_tr[k] = fl_d;
      rd_tr[k] = rsp_data; rv_tr[k] = rsp_valid; er_tr[k] = rsp_err;
      if (rsp_valid && lat < 0) lat = k;
      if (k != 15) step();
    end
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (fl_clk !== 8'hFF) begin fails++; $display("FAIL rst_clk: got %h want ff", fl_clk); end
    tests++; if (fl_rst !== 8'h00) begin fails++; $display("FAIL rst_rst: got %h want 00", fl_rst); end
    tests++; if (fl_set !== 8'h00) begin fails++; $display("FAIL rst_set: got %h want 00", fl_set); end
    tests++; if (fl_d !== 8'h00) begin fails++; $display("FAIL rst_d: got %h want 00", fl_d); end
    tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp: valid=%b err=%b want 0 0", rsp_valid, rsp_err); end
    tests++; if (rsp_data !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h want 00", rsp_data); end
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_load();
    logic [7:0] any_rs;
    issue(2'b00, 8'hFF, 8'hA5);
    any_rs = 8'h00;
    for (int k = 0; k < 16; k++) any_rs |= rst_tr[k] | set_tr[k];
    tests++; if (d_tr[0] !== 8'hA5) begin fails++; $display("FAIL load_d_setup: got %h want a5", d_tr[0]); end
    tests++; if (clk_tr[1] !== 8'hFF) begin fails++; $display("FAIL load_clk_setup: got %h want ff", clk_tr[1]); end
    tests++; if (clk_tr[2] !== 8'h00 || clk_tr[3] !== 8'h00) begin fails++; $display("FAIL load_clk_pulse: got %h %h want 00 00", clk_tr[2], clk_tr[3]); end
    tests++; if (clk_tr[4] !== 8'hFF) begin fails++; $display("FAIL load_clk_hold: got %h want ff", clk_tr[4]); end
    tests++; if (any_rs !== 8'h00) begin fails++; $display("FAIL load_rst_set: got %h want 00", any_rs); end
    tests++; if (lat != 6 + VER) begin fails++; $display("FAIL load_latency: got %0d want %0d", lat, 6 + VER); end
    tests++; if (rd_tr[15] !== (VER ? 8'hA5 : 8'h00) || er_tr[15] !== 1'b0) begin fails++; $display("FAIL load_rsp: data=%h err=%b want %h 0", rd_tr[15], er_tr[15], VER ? 8'hA5 : 8'h00); end
    tests++; if (fl_q !== 8'hA5) begin fails++; $display("FAIL load_q: got %h want a5", fl_q); end
    complete();
    tests++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL load_handshake: ready=%b valid=%b want 1 0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_clear_read();
    logic [7:0] any_set, any_rst, all_clk;
    issue(2'b00, 8'hFF, 8'hFF);
    complete();
    issue(2'b01, 8'h0F, 8'h00);
    any_set = 8'h00; all_clk = 8'hFF;
    for (int k = 0; k < 16; k++) begin any_set |= set_tr[k]; all_clk &= clk_tr[k]; end
    tests++; if (rst_tr[1] !== 8'h00 || rst_tr[4] !== 8'h00) begin fails++; $display("FAIL clr_rst_edges: got %h %h want 00 00", rst_tr[1], rst_tr[4]); end
    tests++; if (rst_tr[2] !== 8'h0F || rst_tr[3] !== 8'h0F) begin fails++; $display("FAIL clr_rst_pulse: got %h %h want 0f 0f", rst_tr[2], rst_tr[3]); end
    tests++; if (any_set !== 8'h00 || all_clk !== 8'hFF) begin fails++; $display("FAIL clr_other_pins: set=%h clk=%h want 00 ff", any_set, all_clk); end
    tests++; if (fl_q !== 8'hF0) begin fails++; $display("FAIL clr_q: got %h want f0", fl_q); end
    tests++; if (lat != 6 + VER) begin fails++; $display("FAIL clr_latency: got %0d want %0d", lat, 6 + VER); end
    complete();
    issue(2'b11, 8'h00, 8'h00);
    any_rst = 8'h00; any_set = 8'h00; all_clk = 8'hFF;
    for (int k = 0; k < 16; k++) begin any_rst |= rst_tr[k]; any_set |= set_tr[k]; all_clk &= clk_tr[k]; end
    tests++; if (lat != 4) begin fails++; $display("FAIL read_latency: got %0d want 4", lat); end
    tests++; if (rd_tr[15] !== 8'hF0 || er_tr[15] !== 1'b0) begin fails++; $display("FAIL read_rsp: data=%h err=%b want f0 0", rd_tr[15], er_tr[15]); end
    tests++; if (any_rst !== 8'h00 || any_set !== 8'h00 || all_clk !== 8'hFF) begin fails++; $display("FAIL read_pins: rst=%h set=%h clk=%h want 00 00 ff", any_rst, any_set, all_clk); end
    tests++; if (d_tr[0] !== 8'hFF) begin fails++; $display("FAIL read_d_retained: got %h want ff", d_tr[0]); end
    complete();
  endtask

  task automatic test_set_mask0();
    logic [7:0] any_rs, all_clk;
    issue(2'b10, 8'h00, 8'h00);
    any_rs = 8'h00; all_clk = 8'hFF;
    for (int k = 0; k < 16; k++) begin any_rs |= rst_tr[k] | set_tr[k]; all_clk &= clk_tr[k]; end
    tests++; if (any_rs !== 8'h00 || all_clk !== 8'hFF) begin fails++; $display("FAIL set0_pins: rs=%h clk=%h want 00 ff", any_rs, all_clk); end
    tests++; if (lat != 6 + VER) begin fails++; $display("FAIL set0_latency: got %0d want %0d", lat, 6 + VER); end
    tests++; if (fl_q !== 8'hF0) begin fails++; $display("FAIL set0_q: got %h want f0", fl_q); end
    complete();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(2'b11, 8'h00, 8'h00);
    cmd_op = 2'b00; cmd_mask = 8'hFF; cmd_data = 8'h00; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || cmd_ready !== 1'b0 || fl_clk !== 8'hFF) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: %0d bad cycles want 0 (valid=%b data=%h ready=%b)", bad, rsp_valid, rsp_data, cmd_ready); end
    cmd_valid = 1'b0;
    complete();
    tests++; if (fl_q !== 8'hF0) begin fails++; $display("FAIL bp_ignored_cmd: q=%h want f0", fl_q); end
    issue(2'b00, 8'hF0, 8'h3C);
    complete();
    tests++; if (fl_q !== 8'h30) begin fails++; $display("FAIL b2b_masked_load: q=%h want 30", fl_q); end
    tests++; if (fl_d !== 8'h3C) begin fails++; $display("FAIL b2b_d_retained: got %h want 3c", fl_d); end
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    cmd_op = 2'b00; cmd_mask = 8'hFF; cmd_data = 8'h00; cmd_valid = 1'b1;
    wait_ready("abort");
    step();
    cmd_valid = 1'b0;
    step();
    step();
    tests++; if (fl_clk !== 8'h00) begin fails++; $display("FAIL abort_in_pulse: clk=%h want 00", fl_clk); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (fl_clk !== 8'hFF || fl_d !== 8'h00) begin fails++; $display("FAIL abort_async: clk=%h d=%h want ff 00", fl_clk, fl_d); end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || fl_clk !== 8'hFF) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL abort_no_rsp: %0d bad cycles want 0", bad); end
  endtask

`ifdef MIOC_SEQ_VERIFY_EN
  task automatic test_verify();
    stuck3 = 1'b1;
    issue(2'b00, 8'hFF, 8'hFF);
    tests++; if (er_tr[15] !== 1'b1 || rd_tr[15] !== 8'hF7) begin fails++; $display("FAIL verify_stuck: err=%b data=%h want 1 f7", er_tr[15], rd_tr[15]); end
    complete();
    stuck3 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_clear_read();
    test_set_mask0();
    test_back_to_back();
    test_reset_abort();
`ifdef MIOC_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mioc_flop_seq.md
Name: mioc_flop_seq

Overview:
Synchronous sequencer that writes and reads back a bank of MIOC open-drain flops. It drives each flop's four pins: async reset (in1), negedge clock (in2), data (in3) and async set (in4). Commands arrive on a valid/ready interface and are turned into glitch-free pin waveforms with programmable setup, pulse and hold times. Flop outputs (q) are sampled back and returned on a response channel. It sits between the control/register logic and the MIOC flop array.

Parameters:
WIDTH, 8, number of flops in the bank
SETUP_CYC, 2, cycles fl_d / settle time before the active edge (>=1)
PULSE_CYC, 2, cycles fl_clk is low, or fl_rst/fl_set is high (>=1)
HOLD_CYC, 1, cycles fl_d is held after fl_clk returns high (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept; high only in IDLE
cmd_op  in  2  00 LOAD, 01 CLEAR, 10 SET, 11 READ
cmd_mask  in  WIDTH  per-flop enable for LOAD/CLEAR/SET
cmd_data  in  WIDTH  LOAD data
fl_rst  out  WIDTH  to flop in1, async reset, active high
fl_clk  out  WIDTH  to flop in2, idle high, falling edge captures
fl_d  out  WIDTH  to flop in3
fl_set  out  WIDTH  to flop in4, async set, active high
fl_q  in  WIDTH  flop q readback
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response accept
rsp_data  out  WIDTH  sampled fl_q (READ, or verify); else 0
rsp_err  out  1  verify mismatch (only with feature enabled)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, fl_clk all 1, fl_rst/fl_set/fl_d all 0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=1 after release. Reset mid-command aborts immediately, with pins returned to idle in the same async event. There is no response for the aborted command.
- All pin outputs are registered; no combinational path from cmd_* to fl_*.
- States: IDLE, SETUP, PULSE, HOLD, SAMPLE, RESP. A single down-counter, sized for max(SETUP_CYC,PULSE_CYC,HOLD_CYC), times each state.
- IDLE: on cmd_valid&&cmd_ready, latch op/mask/data. Go to SETUP with count SETUP_CYC. For LOAD, fl_d <= cmd_data (all bits).
- SETUP: pins stable; fl_clk high. Go to PULSE after SETUP_CYC cycles.
- PULSE, PULSE_CYC cycles:
  - LOAD: fl_clk[i]=0 for mask[i]=1. The falling edge occurs on PULSE entry.
  - CLEAR: fl_rst[i]=1 for mask[i]=1.
  - SET: fl_set[i]=1 for mask[i]=1.
  - Unmasked bits never toggle.
  - fl_rst and fl_set are never high together on any bit.
- HOLD, HOLD_CYC cycles: fl_clk/fl_rst/fl_set back to idle; fl_d unchanged. Then go to SAMPLE if MIOC_SEQ_VERIFY_EN, else RESP.
- READ: IDLE→SETUP (settle) → SAMPLE; skips PULSE/HOLD.
- SAMPLE, 1 cycle: rsp_data <= fl_q.
- RESP: rsp_valid=1. Leave to IDLE on rsp_ready; cmd_ready returns the cycle after.
- Latency, accept edge to rsp_valid high:
  - LOAD/CLEAR/SET: SETUP_CYC+PULSE_CYC+HOLD_CYC+1, plus 1 with verify.
  - READ: SETUP_CYC+2.
- mask=0: full timing runs, no pin toggles, response still issued.
- fl_d is retained after the command until the next LOAD.
- fl_q is treated as settled, because the flops are clocked only by these registered pins.

Optional Feature:
MIOC_SEQ_VERIFY_EN.
- Defined: LOAD/CLEAR/SET pass through SAMPLE. Masked bits of fl_q are compared with the expected value: data, 0 or 1. rsp_err=1 on any mismatch, and rsp_data=sampled fl_q.
- Undefined: the SAMPLE path is removed for those ops, rsp_data=0, and rsp_err is tied 0.
- READ behaves identically in both builds, with rsp_err=0.

Decomposition:
- Package mioc_pkg: op encodings (OP_LOAD/OP_CLEAR/OP_SET/OP_READ), state enum, pin idle constants (CLK_IDLE=1).
- One natural sub-module: mioc_seq_timer (loadable down-counter with done flag), instantiated once by the FSM.

Test Plan:
- Reset with bank behavioural flops: fl_clk=8'hFF and fl_rst/fl_set/fl_d=0 while rst_n=0; cmd_ready=1 after release.
- LOAD data=8'hA5 mask=8'hFF: fl_d=A5 two cycles before the fl_clk fall; fl_clk low 2 cycles; rsp_valid 6 cycles after accept; flops q=A5.
- CLEAR mask=8'h0F after q=FF: fl_rst=0F for 2 cycles, fl_set stays 0, q=F0; then READ → rsp_data=F0 at accept+4.
- SET mask=0 → no pin activity on any bit, response still issued, q unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0; new cmd_valid ignored until handshake.
- Reset asserted in PULSE of LOAD → fl_clk returns to FF asynchronously, no response; with MIOC_SEQ_VERIFY_EN, a flop model forced stuck-at-0 on bit 3 under LOAD FF → rsp_err=1, rsp_data=F7.
